full_add_4: RTL and testbench

4-bit binary adder with carry-in and carry-out, registered at the output. Takes two 4-bit operands and a 1-bit carry-in, and produces a 4-bit sum and a carry-out one clock later. It is a leaf arithmetic block, used directly or as a slice in wider adders by chaining `cout` to the next slice's `Cin`. The core is built from four 1-bit full-adder cells.

---
 rtl/full_add_4_if.sv | 27 ++
 rtl/full_add_4.sv | 93 +++++++++
 tb/tb_full_add_4.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/full_add_4_if.sv
// full_add_4_if -- operand/result bundle for the registered 4-bit adder.
// The master side drives the operands and carry-in and observes the
// registered sum and carry-out; the slave side is the adder itself.
// Signal names match the adder's documented port names (a, b, Cin, s, cout).
interface full_add_4_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       Cin;
    logic [3:0] s;
    logic       cout;

    modport master (
        output a,
        output b,
        output Cin,
        input  s,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  Cin,
        output s,
        output cout
    );
endinterface

// File: rtl/full_add_4.sv
// full_add_4 -- 4-bit unsigned adder with carry-in/carry-out, output registered.
// {cout, s} = a + b + Cin, captured on every rising clk (1-cycle latency).
// Reset rst_n is asynchronous and active-low and clears the output flops.
// Optional macro FULL_ADD_4_CLA_EN: when defined, the ripple carry chain is
// replaced by flat carry-lookahead logic. Results are identical either way;
// only the depth of the combinational path changes.
module full_add_4 (
    input  logic               clk,
    input  logic               rst_n,
    full_add_4_if.slave        bus
);

    logic [3:0] w_sum;
    logic       w_cout;

    logic [3:0] r_s;
    logic       r_cout;

`ifdef FULL_ADD_4_CLA_EN

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic       w_c4;

    // Per-bit generate/propagate terms feeding the lookahead equations
    always_comb begin
        w_g = bus.a & bus.b;
        w_p = bus.a ^ bus.b;
    end

    // Each carry is a flat sum-of-products so no carry waits on another
    always_comb begin
        w_c1 = w_g[0]
             | (w_p[0] & bus.Cin);
        w_c2 = w_g[1]
             | (w_p[1] & w_g[0])
             | (w_p[1] & w_p[0] & bus.Cin);
        w_c3 = w_g[2]
             | (w_p[2] & w_g[1])
             | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & bus.Cin);
        w_c4 = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bus.Cin);
    end

    // Sum bits are still propagate XOR incoming carry
    always_comb begin
        w_sum[0] = w_p[0] ^ bus.Cin;
        w_sum[1] = w_p[1] ^ w_c1;
        w_sum[2] = w_p[2] ^ w_c2;
        w_sum[3] = w_p[3] ^ w_c3;
        w_cout   = w_c4;
    end

`else

    // Ripple chain of four full-adder cells, FA0 (LSB) through FA3 (MSB);
    // the carry is walked through a local variable so each cell sees the
    // previous cell's carry-out
    always_comb begin
        logic v_carry;
        w_sum   = 4'h0;
        v_carry = bus.Cin;
        for (int i = 0; i < 4; i++) begin
            w_sum[i] = bus.a[i] ^ bus.b[i] ^ v_carry;
            v_carry  = (bus.a[i] & bus.b[i]) | (v_carry & (bus.a[i] ^ bus.b[i]));
        end
        w_cout = v_carry;
    end

`endif

    // Capture the 5-bit result every cycle; reset clears it without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= 4'h0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign bus.s    = r_s;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_full_add_4.sv
// tb_full_add_4 -- self-checking bench for full_add_4.
// Expected results are computed from the operands when they are driven,
// queued, and popped when the registered output is sampled one edge later.
module tb_full_add_4;

    logic clk;
    logic rst_n;

    full_add_4_if bus ();

    full_add_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [4:0] expQ [$];
    int         compareCount  = 0;
    int         mismatchCount = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports any difference
    task automatic checkOutput(input string tag, input logic [4:0] observed,
                               input logic [4:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got {cout,s}=%0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one set of operands and queue the reference sum for them
    task automatic applyStimulus(input logic [3:0] aVal, input logic [3:0] bVal,
                                 input logic cinVal);
        logic [4:0] expSum;
        bus.a   = aVal;
        bus.b   = bVal;
        bus.Cin = cinVal;
        expSum  = {1'b0, aVal} + {1'b0, bVal} + {4'b0000, cinVal};
        expQ.push_back(expSum);
    endtask

    // Let one rising edge capture the inputs, then compare against the queue
    task automatic clockAndCollect(input string tag, output logic [4:0] observed);
        @(posedge clk);
        #1;
        observed = {bus.cout, bus.s};
        if (expQ.size() == 0) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL %s: got {cout,s}=%0d, expected a queued result (queue empty)",
                     tag, observed);
        end else begin
            checkOutput(tag, observed, expQ.pop_front());
        end
    endtask

    initial begin
        logic [4:0] obs;
        logic [4:0] bWide;

        // Asynchronous reset with arbitrary inputs, before any clock edge
        rst_n   = 1'b1;
        bus.a   = 4'd9;
        bus.b   = 4'd6;
        bus.Cin = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", {bus.cout, bus.s}, 5'd0);

        // Outputs must hold zero across an edge while reset stays low
        @(posedge clk);
        #1;
        checkOutput("reset_hold", {bus.cout, bus.s}, 5'd0);

        // Release between edges, then first capture
        rst_n = 1'b1;
        applyStimulus(4'd3, 4'd4, 1'b0);
        clockAndCollect("first_3p4", obs);
        checkOutput("first_3p4_const", obs, 5'd7);

        // Sweep b with a=11, Cin=1
        for (int bi = 0; bi < 16; bi++) begin
            applyStimulus(4'd11, 4'(bi), 1'b1);
            clockAndCollect("sweep", obs);
            case (bi)
                0:  checkOutput("sweep_b0",  obs, 5'd12);
                3:  checkOutput("sweep_b3",  obs, 5'd15);
                4:  checkOutput("sweep_b4",  obs, 5'd16);
                15: checkOutput("sweep_b15", obs, 5'd27);
                default: ;
            endcase
        end

        // A value of 16 presented to a 4-bit port wraps to 0
        bWide = 5'd16;
        applyStimulus(4'd11, bWide[3:0], 1'b1);
        clockAndCollect("wrap_b16", obs);
        checkOutput("wrap_b16_const", obs, 5'd12);

        // Extremes
        applyStimulus(4'd0, 4'd0, 1'b0);
        clockAndCollect("ext_zero", obs);
        checkOutput("ext_zero_const", obs, 5'd0);
        applyStimulus(4'd15, 4'd15, 1'b1);
        clockAndCollect("ext_max", obs);
        checkOutput("ext_max_const", obs, 5'd31);
        applyStimulus(4'd15, 4'd0, 1'b1);
        clockAndCollect("ext_propagate", obs);
        checkOutput("ext_propagate_const", obs, 5'd16);

        // Mid-operation reset: a result is in flight and the outputs are nonzero
        applyStimulus(4'd11, 4'd7, 1'b1);
        clockAndCollect("pre_midreset", obs);
        applyStimulus(4'd10, 4'd10, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midreset_async", {bus.cout, bus.s}, 5'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput("midreset_hold", {bus.cout, bus.s}, 5'd0);
        #2 rst_n = 1'b1;
        applyStimulus(4'd5, 4'd9, 1'b0);
        clockAndCollect("post_midreset", obs);
        checkOutput("post_midreset_const", obs, 5'd14);

        // Exhaustive: all 512 operand/carry combinations
        for (int ai = 0; ai < 16; ai++) begin
            for (int bj = 0; bj < 16; bj++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    applyStimulus(4'(ai), 4'(bj), 1'(ci));
                    clockAndCollect("exhaustive", obs);
                end
            end
        end

        if (expQ.size() != 0) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL leftover_queue: got %0d pending results, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
